// File: rtl/regfile_pkg.sv
// Shared register-file definitions: sweep FSM encoding, depth helper and
// default widths used by the datapaths.
package regfile_pkg;

    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned RF_ADDR_W = 5;
    localparam int unsigned RF_NUM_RD = 2;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_SWEEP = 1'b1
    } rf_state_e;

    function automatic int unsigned rf_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/rf_sweep_ctrl.sv
// Zeroing-sweep controller: owns the IDLE/SWEEP FSM, the sweep pointer and
// the write-ready gating, including clear-request restart.
module rf_sweep_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              busy,
    output logic              wr_ready,
    output logic [ADDR_W-1:0] sweep_ptr
);

    localparam int unsigned       DEPTH = rf_depth(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RF_SWEEP;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // A clear request (re)starts the sweep from entry 0 in either state.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (clear_req) begin
            state_d = RF_SWEEP;
            ptr_d   = '0;
        end else begin
            unique case (state_q)
                RF_SWEEP: begin
                    if (ptr_q == LAST) begin
                        state_d = RF_IDLE;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q == RF_SWEEP);
    assign wr_ready  = (state_q == RF_IDLE) && !clear_req;
    assign sweep_ptr = ptr_q;

endmodule

// File: rtl/param_reg_file.sv
// Parametrised register file with sweep-based clearing and optional zero entry.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module param_reg_file
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned NUM_RD   = RF_NUM_RD,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_req,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     busy
);

    localparam int unsigned DEPTH = rf_depth(ADDR_W);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] sweep_ptr;
    logic              wr_fire;
    logic              wr_blocked;

    rf_sweep_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_sweep (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .busy      (busy),
        .wr_ready  (wr_ready),
        .sweep_ptr (sweep_ptr)
    );

    assign wr_fire    = wr_en && wr_ready;
    assign wr_blocked = (ZERO_REG != 0) && (wr_addr == '0);

    // Storage is deliberately unreset; the sweep provides the zero state.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem_q[sweep_ptr] <= '0;
        end else if (wr_fire && !wr_blocked) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;

        assign ra = rd_addr[k*ADDR_W +: ADDR_W];

        // Masking (reset, unswept entries, zero entry) overrides forwarding.
        always_comb begin
            rv = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
            if (wr_fire && (wr_addr == ra)) begin
                rv = wr_data;
            end
`endif
            if (!rst || busy || ((ZERO_REG != 0) && (ra == '0))) begin
                rv = '0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = rv;
    end

endmodule

// File: tb/tb_param_reg_file.sv
// Self-checking bench for param_reg_file (DATA_W=32, ADDR_W=5, NUM_RD=4, ZERO_REG=1).
module tb_param_reg_file;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NR    = 4;
    localparam int unsigned DEPTH = 32;

    logic             clk;
    logic             rst;
    logic             clear_req;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             wr_ready;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;

    param_reg_file #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_RD   (NR),
        .ZERO_REG (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: contents plus number of busy cycles still to go.
    logic [DW-1:0] m_mem [DEPTH];
    int            sweep_left = DEPTH;

    function automatic logic exp_busy();
        return !rst || (sweep_left > 0);
    endfunction

    function automatic logic exp_wr_ready();
        return !exp_busy() && !clear_req;
    endfunction

    function automatic logic [DW-1:0] exp_rd(input int k);
        logic [AW-1:0] a;
        a = rd_addr[k*AW +: AW];
        if (exp_busy() || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && exp_wr_ready() && wr_addr == a) return wr_data;
`endif
        return m_mem[a];
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            sweep_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end else begin
            logic acc;
            acc = wr_en && exp_wr_ready();
            if (clear_req) begin
                sweep_left = DEPTH;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            end else if (sweep_left > 0) begin
                sweep_left--;
            end
            if (acc && wr_addr != 0) m_mem[wr_addr] = wr_data;
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        for (int k = 0; k < NR; k++) chk($sformatf("rd%0d", k), rd_data[k*DW +: DW], exp_rd(k));
        chk("busy", 32'(busy), 32'(exp_busy()));
        chk("wr_ready", 32'(wr_ready), 32'(exp_wr_ready()));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    function automatic logic [NR*AW-1:0] addrs(input int a3, input int a2, input int a1, input int a0);
        return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endfunction

    initial begin
        rst = 1'b0; clear_req = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = addrs(7, 3, 1, 0);

        // Reset state
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_rd1", rd_data[1*DW +: DW], 32'h0);
        tick(); tick();
        rst = 1'b1;

        // Initial sweep lasts exactly DEPTH cycles
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("sweep_busy", 32'(busy), 32'd1);
            tick();
        end
        @(negedge clk);
        chk("sweep_done", 32'(busy), 32'd0);
        for (int a = 0; a < DEPTH / NR; a++) begin
            rd_addr = addrs(a*4+3, a*4+2, a*4+1, a*4);
            tick();
        end

        // Write to 7 and observe same-cycle / next-cycle visibility
        rd_addr = addrs(0, 0, 0, 7);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF;
        @(negedge clk);
`ifdef REGFILE_BYPASS_EN
        chk("wr7_same", rd_data[DW-1:0], 32'hDEADBEEF);
`else
        chk("wr7_same", rd_data[DW-1:0], 32'h0);
`endif
        tick();
        wr_en = 1'b0;
        @(negedge clk);
        chk("wr7_next", rd_data[DW-1:0], 32'hDEADBEEF);

        // Zero entry accepts the write but always reads 0
        rd_addr = addrs(0, 0, 0, 0);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
        @(negedge clk);
        chk("zero_wr_ready", 32'(wr_ready), 32'd1);
        tick();
        wr_en = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NR; k++) chk("zero_rd", rd_data[k*DW +: DW], 32'h0);

        // Multi-port reads
        wr(5'd9, 32'h0000FFFF);
        wr(5'd1, 32'h11111111);
        wr(5'd2, 32'h22222222);
        wr(5'd3, 32'h33333333);
        wr(5'd4, 32'h44444444);
        rd_addr = addrs(9, 9, 9, 9);
        @(negedge clk);
        for (int k = 0; k < NR; k++) chk("same_addr", rd_data[k*DW +: DW], 32'h0000FFFF);
        tick();
        rd_addr = addrs(4, 3, 2, 1);
        @(negedge clk);
        chk("port0_a1", rd_data[0*DW +: DW], 32'h11111111);
        chk("port1_a2", rd_data[1*DW +: DW], 32'h22222222);
        chk("port2_a3", rd_data[2*DW +: DW], 32'h33333333);
        chk("port3_a4", rd_data[3*DW +: DW], 32'h44444444);
        tick();

        // Write coincident with clear is dropped; restart mid-sweep
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5; clear_req = 1'b1;
        @(negedge clk);
        chk("clr_wr_ready", 32'(wr_ready), 32'd0);
        tick();
        wr_en = 1'b0; clear_req = 1'b0;
        repeat (10) tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("restart_busy", 32'(busy), 32'd1);
            tick();
        end
        @(negedge clk);
        chk("restart_done", 32'(busy), 32'd0);
        rd_addr = addrs(9, 4, 1, 3);
        @(negedge clk);
        chk("clr_a3", rd_data[0*DW +: DW], 32'h0);
        chk("clr_a9", rd_data[3*DW +: DW], 32'h0);
        tick();

        // Reset mid-sweep, writes during the new sweep are lost
        wr(5'd5, 32'h55555555);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (15) tick();
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        rd_addr = addrs(0, 0, 0, 5);
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hCAFEF00D;
            @(negedge clk);
            chk("rst_sweep_busy", 32'(busy), 32'd1);
            chk("rst_sweep_wr_ready", 32'(wr_ready), 32'd0);
            tick();
        end
        wr_en = 1'b0;
        @(negedge clk);
        chk("rst_sweep_done", 32'(busy), 32'd0);
        chk("rst_sweep_a5", rd_data[DW-1:0], 32'h0);
        tick();

        // Mixed traffic checked by the model
        for (int i = 0; i < 300; i++) begin
            wr_en     = 1'($urandom_range(0, 1));
            wr_addr   = AW'($urandom_range(0, DEPTH - 1));
            wr_data   = $urandom;
            rd_addr   = (NR*AW)'($urandom);
            clear_req = ($urandom_range(0, 59) == 0);
            tick();
        end
        clear_req = 1'b0; wr_en = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
